// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// The slave side is the LSU; the master side is the core plus memory environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, mem_RD,
    output req_ready, done, err, rdata, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, funct3, addr, wdata, mem_RD,
    input  req_ready, done, err, rdata, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 32-bit word-addressed, little-endian data memory.
// Sub-word stores are done as read-modify-write; errors complete without touching memory.
module load_store_unit (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    ERR
  } state_t;

  state_t      state, state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic [31:0] load_val;
  logic [31:0] store_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign accept = (state == IDLE) && bus.req_valid;

  // Decode of the incoming request, only meaningful while IDLE.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we) begin
      legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
    end else begin
      legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
              (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
    end
    if (bus.funct3[1:0] == 2'b01) begin
      misaligned = bus.addr[0];
    end else if (bus.funct3[1:0] == 2'b10) begin
      misaligned = (bus.addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!legal || misaligned) begin
            state_d = ERR;
          end else if (bus.req_we && (bus.funct3 == 3'b010)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};

  // Lane select and extension of the word currently on mem_RD.
  always_comb begin
    byte_v   = 8'(bus.mem_RD >> byte_sh);
    half_v   = 16'(bus.mem_RD >> half_sh);
    load_val = bus.mem_RD;
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'h000000, byte_v};
      3'b101:  load_val = {16'h0000, half_v};
      default: load_val = bus.mem_RD;
    endcase
  end

  // Merge of the store data into the word captured during READ.
  always_comb begin
    store_val = '0;
    if (state == WRITE) begin
      case (f3_q[1:0])
        2'b00:   store_val = (word_q & ~(32'h0000_00FF << byte_sh)) |
                             ({24'h000000, wdata_q[7:0]} << byte_sh);
        2'b01:   store_val = (word_q & ~(32'h0000_FFFF << half_sh)) |
                             ({16'h0000, wdata_q[15:0]} << half_sh);
        default: store_val = wdata_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        f3_q    <= bus.funct3;
        we_q    <= bus.req_we;
      end
      if (state == READ) begin
        word_q <= bus.mem_RD;
        if (!we_q) begin
          rdata_q <= load_val;
        end
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops mem_WE at once.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.done      = (state == RESP) || (state == ERR);
    bus.err       = (state == ERR);
    bus.mem_WE    = (state == WRITE);
    bus.mem_WD    = store_val;
    bus.mem_A     = addr_q;
    bus.rdata     = rdata_q;
  end

endmodule
